// File: rtl/transpose_psum_accumulator_if.sv
// rtl/transpose_psum_accumulator_if.sv - partial-sum input and drain output streams of the psum accumulator
interface transpose_psum_accumulator_if #(
    parameter int DW = 16,
    parameter int AW = 5
);
    logic          partial_valid;
    logic [3:0]    col_id;
    logic [DW-1:0] partial_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;

    modport master (
        output partial_valid, col_id, partial_in, out_ready,
        input  out_valid, out_data, out_addr, out_last
    );

    modport slave (
        input  partial_valid, col_id, partial_in, out_ready,
        output out_valid, out_data, out_addr, out_last
    );
endinterface

// File: rtl/transpose_psum_accumulator.sv
// rtl/transpose_psum_accumulator.sv - overlap-add row accumulator with saturating drain stream
module transpose_psum_accumulator #(
    parameter int  DW    = 16,
    parameter int  ACC_W = 24,
    parameter int  DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tile_start,
    input  logic [AW-1:0]                 tile_base,
    input  logic                          flush_start,
    transpose_psum_accumulator_if.slave   bus,
    output logic                          busy,
    output logic                          flush_done,
    output logic                          err_drop
);
    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t                   state;
    logic [AW-1:0]            base;
    logic [AW-1:0]            ptr;
    logic                     out_valid_q;
    logic signed [ACC_W-1:0]  acc [DEPTH];

    logic [AW-1:0]            eff_base;
    logic [AW-1:0]            wr_addr;
    logic signed [ACC_W-1:0]  addend;
    logic signed [ACC_W-1:0]  rd_val;
    logic [DW-1:0]            sat_val;
    logic                     xfer;

    // A tile_start coinciding with a partial already steers that partial, unless flush wins the cycle
    assign eff_base = (state == ACCUM && tile_start && !flush_start) ? tile_base : base;
    assign wr_addr  = eff_base + AW'(bus.col_id);
    assign addend   = {{(ACC_W-DW){bus.partial_in[DW-1]}}, bus.partial_in};
    assign rd_val   = acc[ptr];
    assign xfer     = out_valid_q && bus.out_ready;

    always_comb begin
        sat_val = rd_val[DW-1:0];
        if (rd_val > SAT_MAX)
            sat_val = SAT_MAX[DW-1:0];
        else if (rd_val < SAT_MIN)
            sat_val = SAT_MIN[DW-1:0];
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? sat_val : '0;
    assign bus.out_addr  = ptr;
    assign bus.out_last  = out_valid_q && (ptr == LAST_ADDR);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base        <= '0;
            ptr         <= '0;
            out_valid_q <= 1'b0;
            flush_done  <= 1'b0;
            err_drop    <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                acc[i] <= '0;
        end else begin
            flush_done <= 1'b0;
            if (bus.partial_valid && state != ACCUM)
                err_drop <= 1'b1;
            case (state)
                IDLE: begin
                    if (tile_start) begin
                        base  <= tile_base;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    // Flop-array storage makes the update visible next cycle, so back-to-back hits add fully
                    if (bus.partial_valid)
                        acc[wr_addr] <= acc[wr_addr] + addend;
                    if (flush_start) begin
                        state       <= FLUSH;
                        ptr         <= '0;
                        out_valid_q <= 1'b1;
                    end else if (tile_start) begin
                        base <= tile_base;
                    end
                end
                FLUSH: begin
                    if (xfer) begin
                        acc[ptr] <= '0;
                        if (ptr == LAST_ADDR) begin
                            state       <= IDLE;
                            ptr         <= '0;
                            out_valid_q <= 1'b0;
                            flush_done  <= 1'b1;
                        end else begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
